fb_scanout: RTL

- Display read-out stage directly downstream of the frame buffer filled by the map drawer.
- Scans the 320x240, 24-bit frame buffer and drives 640x480@60 VGA timing, doubling each stored pixel horizontally and vertically.
- Emits a one-clock vblank pulse that the map drawer's start input can use, so redraws begin outside the visible region.

---
 rtl/fb_scanout.sv | 99 +++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// Frame buffer read-out: scans a 320x240 buffer with pixel doubling
// and drives 640x480@60 VGA timing with a 2-tick output pipeline.
module fb_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int FB_W   = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        en,
    output logic [16:0] fb_rd_addr,
    input  logic [23:0] fb_rd_data,
    output logic [23:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        vblank_pulse
);

    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [9:0]  h;
    logic [9:0]  v;
    logic [16:0] line_base;
    logic        vis0;
    logic        hs0;
    logic        vs0;
    logic        h_last;
    logic        v_last;
    logic        vis1;
    logic        hs1;
    logic        vs1;

    always_comb begin
        vis0   = (h < 10'(H_VIS)) && (v < 10'(V_VIS));
        hs0    = !((h >= 10'(HS_START)) && (h < 10'(HS_END)));
        vs0    = !((v >= 10'(VS_START)) && (v < 10'(VS_END)));
        h_last = (h == 10'(H_TOT - 1));
        v_last = (v == 10'(V_TOT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h            <= '0;
            v            <= '0;
            line_base    <= '0;
            fb_rd_addr   <= '0;
            vis1         <= 1'b0;
            hs1          <= 1'b1;
            vs1          <= 1'b1;
            rgb          <= '0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            blank        <= 1'b1;
            vblank_pulse <= 1'b0;
        end else begin
            vblank_pulse <= 1'b0;
            if (pix_en) begin
                if (h_last) begin
                    h <= '0;
                    if (v_last) begin
                        v         <= '0;
                        line_base <= '0;
                    end else begin
                        v <= v + 10'd1;
                        // odd line done: the next pair of lines reads the next row
                        if (v[0])
                            line_base <= line_base + 17'(FB_W);
                    end
                end else begin
                    h <= h + 10'd1;
                end
                if (vis0)
                    fb_rd_addr <= line_base + {8'd0, h[9:1]};
                vis1         <= vis0;
                hs1          <= hs0;
                vs1          <= vs0;
                rgb          <= vis1 ? fb_rd_data : 24'd0;
                hsync        <= hs1;
                vsync        <= vs1;
                blank        <= !vis1;
                vblank_pulse <= h_last && (v == 10'(V_VIS - 1));
            end
        end
    end

endmodule
